// File: rtl/fft_pkg.sv
// Shared fixed-point helpers for the FFT datapath: Q-format convention,
// round-half-up shifting and saturation with an overflow indication.
package fft_pkg;

  // Twiddles are Q1.(TW_WIDTH-1): this many fractional bits.
  function automatic int unsigned tw_frac(input int unsigned tw_width);
    return tw_width - 1;
  endfunction

  // Round half up: add 2^(sh-1), then arithmetic shift right by sh (sh >= 1).
  function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] x,
                                                 input int unsigned sh);
    logic signed [63:0] half;
    half = 64'sd1 <<< (sh - 1);
    return (x + half) >>> sh;
  endfunction

  // Clip x to the signed range of w bits; ovf reports whether clipping occurred.
  function automatic logic signed [63:0] saturate(input  logic signed [63:0] x,
                                                  input  int unsigned        w,
                                                  output logic               ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    ovf = (x > hi) || (x < lo);
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/cmul_rnd.sv
// Two-stage pipelined complex multiply B*W (or B*conj(W)) with Q-format
// round-half-up; both stages advance together on en.
module cmul_rnd
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TW_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         inv,
  input  logic signed [DATA_WIDTH-1:0] b_re,
  input  logic signed [DATA_WIDTH-1:0] b_im,
  input  logic signed [TW_WIDTH-1:0]   w_re,
  input  logic signed [TW_WIDTH-1:0]   w_im,
  output logic signed [DATA_WIDTH+1:0] p_re,
  output logic signed [DATA_WIDTH+1:0] p_im
);
  localparam int unsigned PW = DATA_WIDTH + TW_WIDTH;
  localparam int unsigned SW = PW + 1;

  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic                 inv_q;
  logic signed [SW-1:0] s_re, s_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr  <= '0;
      m_ii  <= '0;
      m_ri  <= '0;
      m_ir  <= '0;
      inv_q <= 1'b0;
    end else if (en) begin
      m_rr  <= PW'(b_re) * PW'(w_re);
      m_ii  <= PW'(b_im) * PW'(w_im);
      m_ri  <= PW'(b_re) * PW'(w_im);
      m_ir  <= PW'(b_im) * PW'(w_re);
      inv_q <= inv;
    end
  end

  // Conjugation flips the product signs instead of negating w_im, so w_im = -1.0 stays exact.
  always_comb begin
    s_re = inv_q ? (SW'(m_rr) + SW'(m_ii)) : (SW'(m_rr) - SW'(m_ii));
    s_im = inv_q ? (SW'(m_ir) - SW'(m_ri)) : (SW'(m_ri) + SW'(m_ir));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re <= '0;
      p_im <= '0;
    end else if (en) begin
      p_re <= (DATA_WIDTH + 2)'(rnd_shr(64'(s_re), tw_frac(TW_WIDTH)));
      p_im <= (DATA_WIDTH + 2)'(rnd_shr(64'(s_im), tw_frac(TW_WIDTH)));
    end
  end

endmodule

// File: rtl/bfly_2p_pipe.sv
// Radix-2 DIT butterfly, 3-cycle pipeline: Y0 = A + B*W, Y1 = A - B*W with
// optional conj(W), optional /2 scaling, saturation and a sticky overflow flag.
module bfly_2p_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TW_WIDTH   = 16,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] a_re,
  input  logic signed [DATA_WIDTH-1:0] a_im,
  input  logic signed [DATA_WIDTH-1:0] b_re,
  input  logic signed [DATA_WIDTH-1:0] b_im,
  input  logic signed [TW_WIDTH-1:0]   w_re,
  input  logic signed [TW_WIDTH-1:0]   w_im,
  input  logic                         inv,
  input  logic                         scale,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] y0_re,
  output logic signed [DATA_WIDTH-1:0] y0_im,
  output logic signed [DATA_WIDTH-1:0] y1_re,
  output logic signed [DATA_WIDTH-1:0] y1_im,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic                         ovf,
  input  logic                         ovf_clr
);
  localparam int unsigned PW = DATA_WIDTH + 2;
  localparam int unsigned SW = DATA_WIDTH + 3;

  logic                         adv;
  logic                         v1, v2, sc1, sc2, y_sat;
  logic signed [DATA_WIDTH-1:0] a1_re, a1_im, a2_re, a2_im;
  logic [TAG_WIDTH-1:0]         tag1, tag2;
  logic signed [PW-1:0]         p_re, p_im;
  logic signed [SW-1:0]         s0_re, s0_im, s1_re, s1_im;
  logic signed [DATA_WIDTH-1:0] n0_re, n0_im, n1_re, n1_im;
  logic [3:0]                   sat;

  // One global enable: the whole pipe stalls together, in_ready follows out_ready combinationally.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  cmul_rnd #(
    .DATA_WIDTH(DATA_WIDTH),
    .TW_WIDTH  (TW_WIDTH)
  ) u_cmul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (adv),
    .inv  (inv),
    .b_re (b_re),
    .b_im (b_im),
    .w_re (w_re),
    .w_im (w_im),
    .p_re (p_re),
    .p_im (p_im)
  );

  function automatic logic signed [63:0] fin(input logic signed [SW-1:0] s, input logic sc);
    return sc ? rnd_shr(64'(s), 1) : 64'(s);
  endfunction

  always_comb begin
    sat   = '0;
    s0_re = SW'(a2_re) + SW'(p_re);
    s0_im = SW'(a2_im) + SW'(p_im);
    s1_re = SW'(a2_re) - SW'(p_re);
    s1_im = SW'(a2_im) - SW'(p_im);
    n0_re = DATA_WIDTH'(saturate(fin(s0_re, sc2), DATA_WIDTH, sat[0]));
    n0_im = DATA_WIDTH'(saturate(fin(s0_im, sc2), DATA_WIDTH, sat[1]));
    n1_re = DATA_WIDTH'(saturate(fin(s1_re, sc2), DATA_WIDTH, sat[2]));
    n1_im = DATA_WIDTH'(saturate(fin(s1_im, sc2), DATA_WIDTH, sat[3]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;  v2 <= 1'b0;  out_valid <= 1'b0;
      sc1 <= 1'b0; sc2 <= 1'b0;
      a1_re <= '0; a1_im <= '0; a2_re <= '0; a2_im <= '0;
      tag1 <= '0;  tag2 <= '0;  out_tag <= '0;
      y0_re <= '0; y0_im <= '0; y1_re <= '0; y1_im <= '0;
      y_sat <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (adv) begin
        v1        <= in_valid;
        a1_re     <= a_re;
        a1_im     <= a_im;
        sc1       <= scale;
        tag1      <= in_tag;
        v2        <= v1;
        a2_re     <= a1_re;
        a2_im     <= a1_im;
        sc2       <= sc1;
        tag2      <= tag1;
        out_valid <= v2;
        if (v2) begin
          y0_re   <= n0_re;
          y0_im   <= n0_im;
          y1_re   <= n1_re;
          y1_im   <= n1_im;
          out_tag <= tag2;
          y_sat   <= |sat;
        end
      end
      // Saturation is flagged when the clipped result is actually handed off; set beats clear.
      if (out_valid && out_ready && y_sat) ovf <= 1'b1;
      else if (ovf_clr)                    ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bfly_2p_pipe.sv
// Directed bench for bfly_2p_pipe with a scoreboard of mathematically computed results.
module tb_bfly_2p_pipe;
  localparam int DW  = 16;
  localparam int TW  = 16;
  localparam int TGW = 8;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, inv, scale, out_valid, out_ready, ovf, ovf_clr;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im, y0_re, y0_im, y1_re, y1_im;
  logic signed [TW-1:0] w_re, w_im;
  logic [TGW-1:0] in_tag, out_tag;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  typedef struct {
    longint y0r, y0i, y1r, y1i;
    logic [TGW-1:0] tag;
    bit sat;
  } exp_t;

  exp_t q[$];
  bit   m_ovf = 1'b0;

  bfly_2p_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .TAG_WIDTH(TGW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .inv(inv), .scale(scale), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .out_tag(out_tag), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    longint qv;
    qv = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) qv--;
    return qv;
  endfunction

  // Nearest integer to x / 2^sh, ties toward +infinity.
  function automatic longint rnd_q(input longint x, input int sh);
    return floor_div(2 * x + (longint'(1) << sh), longint'(1) << (sh + 1));
  endfunction

  function automatic longint clamp(input longint v, inout bit s);
    longint hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (v > hi) begin s = 1'b1; return hi; end
    if (v < lo) begin s = 1'b1; return lo; end
    return v;
  endfunction

  function automatic exp_t model(input longint ar, ai, br, bi, wr, wi,
                                 input bit iv, sc, input logic [TGW-1:0] tg);
    exp_t e;
    longint wc, pr, pi, t0r, t0i, t1r, t1i;
    wc  = iv ? -wi : wi;
    pr  = rnd_q(br * wr - bi * wc, TW - 1);
    pi  = rnd_q(br * wc + bi * wr, TW - 1);
    t0r = ar + pr; t0i = ai + pi; t1r = ar - pr; t1i = ai - pi;
    if (sc) begin
      t0r = rnd_q(t0r, 1); t0i = rnd_q(t0i, 1); t1r = rnd_q(t1r, 1); t1i = rnd_q(t1i, 1);
    end
    e.sat = 1'b0;
    e.y0r = clamp(t0r, e.sat);
    e.y0i = clamp(t0i, e.sat);
    e.y1r = clamp(t1r, e.sat);
    e.y1i = clamp(t1i, e.sat);
    e.tag = tg;
    return e;
  endfunction

  // Scoreboard: checks every cycle, records input transfers, retires output transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_y0_re", y0_re, 0);
      chk("rst_out_tag", out_tag, 0);
    end else begin
      bit nxt;
      nxt = m_ovf;
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      chk("ovf_model", ovf, m_ovf);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: tag %0d with no pending transaction", out_tag);
        end else begin
          chk("sb_y0_re", y0_re, q[0].y0r);
          chk("sb_y0_im", y0_im, q[0].y0i);
          chk("sb_y1_re", y1_re, q[0].y1r);
          chk("sb_y1_im", y1_im, q[0].y1i);
          chk("sb_tag", out_tag, q[0].tag);
          if (out_ready) begin
            if (q[0].sat) nxt = 1'b1;
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (!(out_valid && out_ready && nxt && !m_ovf) && ovf_clr && !(out_valid && out_ready && q.size() >= 0 && nxt != m_ovf))
        nxt = (nxt && !m_ovf) ? 1'b1 : 1'b0;
      m_ovf = nxt;
      if (in_valid && in_ready)
        q.push_back(model(longint'(a_re), longint'(a_im), longint'(b_re), longint'(b_im),
                          longint'(w_re), longint'(w_im), inv, scale, in_tag));
    end
  end

  task automatic set_in(input longint ar, ai, br, bi, wr, wi, input bit iv, sc, input logic [TGW-1:0] tg);
    a_re = DW'(ar); a_im = DW'(ai); b_re = DW'(br); b_im = DW'(bi);
    w_re = TW'(wr); w_im = TW'(wi); inv = iv; scale = sc; in_tag = tg;
  endtask

  // One isolated transaction into an empty pipe; checks latency, literal results and ovf afterwards.
  task automatic send_one(input string nm, input longint ar, ai, br, bi, wr, wi,
                          input bit iv, sc, input logic [TGW-1:0] tg, input bit clr_at_out,
                          input longint e0r, e0i, e1r, e1i, input bit eovf);
    @(posedge clk); #1;
    set_in(ar, ai, br, bi, wr, wi, iv, sc, tg);
    in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_lat2"}, out_valid, 0);
    @(posedge clk); #1;
    ovf_clr = clr_at_out;
    @(negedge clk);
    chk({nm, "_lat3"}, out_valid, 1);
    chk({nm, "_y0_re"}, y0_re, e0r);
    chk({nm, "_y0_im"}, y0_im, e0i);
    chk({nm, "_y1_re"}, y1_re, e1r);
    chk({nm, "_y1_im"}, y1_im, e1i);
    chk({nm, "_tag"}, out_tag, tg);
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk({nm, "_ovf"}, ovf, eovf);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int base;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send_one("fwd",   1000, 0, 2000, 0, 32767, 0,      1'b0, 1'b0, 8'd1, 1'b0, 3000, 0, -1000, 0, 1'b0);
    send_one("scale", 1000, 0, 2000, 0, 32767, 0,      1'b0, 1'b1, 8'd2, 1'b0, 1500, 0, -500, 0, 1'b0);
    send_one("inv1",  0, 0, 100, 0, 0, -32768,         1'b1, 1'b0, 8'd3, 1'b0, 0, 100, 0, -100, 1'b0);
    send_one("inv0",  0, 0, 100, 0, 0, -32768,         1'b0, 1'b0, 8'd4, 1'b0, 0, -100, 0, 100, 1'b0);
    send_one("sat",   32767, 0, 32767, 0, 32767, 0,    1'b0, 1'b0, 8'd5, 1'b0, 32767, 0, 1, 0, 1'b1);
    send_one("sticky", 1000, 0, 2000, 0, 32767, 0,     1'b0, 1'b0, 8'd6, 1'b0, 3000, 0, -1000, 0, 1'b1);

    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf, 0);

    send_one("set_wins", 32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 8'd7, 1'b1, 32767, 0, 1, 0, 1'b1);

    // Eight tagged transactions with the consumer stalled in cycles 4..8.
    idx  = 0;
    base = n_out;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c <= 8);
      if (idx < 8) begin
        set_in(idx * 1000 - 3000, 500 - idx * 300, 4000 + idx * 111, -2000 + idx * 77,
               23170, -23170, (idx % 2) == 1, ((idx / 2) % 2) == 1, TGW'(idx));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 4 && c <= 8) chk("bp_in_ready_low", in_ready, 0);
      if (c == 6) chk("bp_held_tag", out_tag, 1);
      if (in_valid && in_ready) idx++;
      if (idx == 8 && q.size() == 0 && c > 8) break;
    end
    chk("bp_all_out", n_out - base, 8);
    chk("bp_drained", q.size(), 0);
    out_ready = 1'b1;

    // Reset with three transactions in flight.
    chk("pre_rst_ovf", ovf, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_in(100 * i, 0, 2000, 0, 32767, 0, 1'b0, 1'b0, TGW'(8'h40 + i));
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send_one("post_rst", 1000, 0, 2000, 0, 32767, 0, 1'b0, 1'b0, 8'h55, 1'b0, 3000, 0, -1000, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("final_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bfly_2p_pipe.md
# bfly_2p_pipe

Pipelined, parametrised radix-2 decimation-in-time butterfly computing Y0 = A + B·W and Y1 = A − B·W. It has a fixed 3-cycle latency and a valid/ready stream handshake. Per-transaction options are forward/inverse twiddle (conjugate W) and ×½ scaling with round-half-up. Outputs saturate to DATA_WIDTH, with a sticky overflow flag. It is the building block for the streaming multi-stage FFT engines, replacing the purely combinational 2-point butterfly.

## Interface
- DATA_WIDTH, 16, signed two's-complement width of every A/B/Y component
- TW_WIDTH, 16, signed twiddle component width; Q1.(TW_WIDTH−1) format, so 0x8000 = −1.0 and 0x7FFF ≈ +1.0
- TAG_WIDTH, 8, sideband width (sample index/frame info), carried unmodified with the data
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept; a transfer happens when in_valid && in_ready
- a_re, a_im, b_re, b_im  in  DATA_WIDTH each  operands
- w_re, w_im  in  TW_WIDTH each  twiddle
- inv  in  1  1 = use conj(W) (IFFT)
- scale  in  1  1 = outputs divided by 2 (round half up)
- in_tag  in  TAG_WIDTH  sideband
- out_valid  out  1  output valid
- out_ready  in  1  downstream accept
- y0_re, y0_im, y1_re, y1_im  out  DATA_WIDTH each  results
- out_tag  out  TAG_WIDTH  sideband aligned with the results
- ovf  out  1  sticky: set when any output component saturated
- ovf_clr  in  1  synchronous clear of ovf

## Operation
- Stage 1: register A, inv, scale and tag. Form the four full products b_re·w_re, b_im·w_im, b_re·w_im and b_im·w_re at DATA_WIDTH+TW_WIDTH bits each.
- Stage 2: compute the product terms and round.
  - inv=0: P_re = b_re·w_re − b_im·w_im; P_im = b_re·w_im + b_im·w_re.
  - inv=1: P_re = b_re·w_re + b_im·w_im; P_im = b_im·w_re − b_re·w_im.
  - Conjugation is done by swapping these signs, never by negating w_im, so W = −1.0j stays exact.
  - Each sum is DATA_WIDTH+TW_WIDTH+1 bits. Add 2^(TW_WIDTH−2), then arithmetic-shift right by TW_WIDTH−1, and keep DATA_WIDTH+2 bits.
- Stage 3: compute S0 = A + P and S1 = A − P at DATA_WIDTH+3 bits.
  - If scale=1: add 1, then arithmetic-shift right by 1.
  - Saturate each component to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- ovf behaviour:
  - Any of the 4 components saturating on an output transfer sets ovf.
  - ovf_clr in the same cycle as a new saturation leaves ovf = 1 (set wins).
- Flow control is one global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=0, all three stages, including valid bits, hold.
  - Bubbles are not compressed. Throughput is 1 transaction/cycle when out_ready stays high.
- Order is strictly preserved. The tag travels the same path as the data.

## Timing
- Latency: a transfer in cycle N gives out_valid in cycle N+3, provided adv stays high.
- Reset (asynchronous, any time including mid-stream):
  - All stage valid bits are 0, so out_valid=0.
  - ovf=0; y*, out_tag = 0.
  - In-flight transactions are discarded.
  - in_ready=1 during and after reset.
- Output data and out_tag are stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready (no skid buffer). This is documented for integrators.
- When no transfer happens, Y registers hold their previous value; only the valid bits carry meaning.

## Structure
- Shared package fft_pkg holds:
  - the rounding helper function (add-half, shift),
  - the saturate function returning the clipped value and an overflow bit,
  - the Q-format constant TW_FRAC = TW_WIDTH−1 convention.
- Sub-module cmul_rnd covers stages 1–2 (pipelined complex multiply with conj option and rounding, 2 cycles, shared enable). It is reusable by later radix-4 blocks.
- The top level adds stage 3, the valid pipeline, the tag delay and ovf.

## Test plan
- Forward multiply:
  - Stimulus: A=(1000,0), B=(2000,0), W=(0x7FFF,0), inv=0, scale=0.
  - Response: Y0=(3000,0), Y1=(−1000,0) three cycles later; ovf=0.
- Scaling:
  - Stimulus: same inputs with scale=1.
  - Response: Y0=(1500,0), Y1=(−500,0).
- Inverse twiddle:
  - Stimulus: A=(0,0), B=(100,0), W=(0,−32768), inv=1.
  - Response: Y0=(0,100), Y1=(0,−100).
  - With inv=0 the response is Y0=(0,−100), Y1=(0,100).
- Saturation:
  - Stimulus: A=(32767,0), B=(32767,0), W=(0x7FFF,0).
  - Response: Y0=(32767,0) with ovf→1; Y1=(1,0).
  - ovf stays set until ovf_clr is pulsed; a pulse with no new saturation clears it.
- Backpressure:
  - Stimulus: stream 8 tagged transactions (tags 0..7) with out_ready low for cycles 4–8.
  - Response: in_ready low while stalled; outputs held stable; all 8 appear in tag order with no loss or duplication.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 with 3 transactions in flight.
  - Response: out_valid=0 immediately; ovf=0; nothing from before reset emerges afterwards; the first post-reset input appears after exactly 3 cycles.
